// File: rtl/key_matrix_scanner.sv
// Column-at-a-time scanner for an N x N active-low key matrix.
// Each cell is debounced independently and published as a packed N*N vector.
module key_matrix_scanner #(
  parameter int N              = 3,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N-1:0]         row_sense,
  output logic [N-1:0]         cols,
  output logic [$clog2(N):0]   x,
  output logic [N*N-1:0]       cells,
  output logic                 frame_done,
  output logic                 cells_changed
);

  localparam int XW = $clog2(N) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  if (N < 1 || N > 8) begin : g_bad_n
    $error("key_matrix_scanner: N must be in 1..8");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("key_matrix_scanner: SETTLE_CYCLES must be >= 1");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("key_matrix_scanner: DEBOUNCE_SCANS must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t          state, state_d;
  logic [XW-1:0]   x_d;
  logic [SW-1:0]   settle_cnt, settle_d;
  logic            frame_done_d;
  logic            flipped, flip_now;
  logic [N*N-1:0]  cells_d;
  logic [DW-1:0]   deb_cnt [N*N];
  logic [DW-1:0]   deb_d   [N*N];

  always_comb begin
    state_d      = state;
    x_d          = x;
    settle_d     = settle_cnt;
    frame_done_d = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          state_d  = SETTLE;
          x_d      = '0;
          settle_d = '0;
        end
      end
      SETTLE: begin
        settle_d = settle_cnt + SW'(1);
        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        settle_d = '0;
        if (x == XW'(N - 1)) begin
          // ena is only honoured at frame end, so frames are never cut short
          x_d          = '0;
          frame_done_d = 1'b1;
          state_d      = ena ? SETTLE : IDLE;
        end else begin
          x_d     = x + XW'(1);
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the cells of the column being sampled see row_sense this cycle
  always_comb begin
    cells_d  = cells;
    deb_d    = deb_cnt;
    flip_now = 1'b0;
    for (int c = 0; c < N*N; c++) begin
      if (state == SAMPLE && x == XW'(c / N)) begin
        if (~row_sense[c % N] == cells[c]) begin
          deb_d[c] = '0;
        end else if (deb_cnt[c] + DW'(1) == DW'(DEBOUNCE_SCANS)) begin
          cells_d[c] = ~cells[c];
          deb_d[c]   = '0;
          flip_now   = 1'b1;
        end else begin
          deb_d[c] = deb_cnt[c] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    cols = '0;
    if (state != IDLE) cols = N'(1) << x;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      x             <= '0;
      settle_cnt    <= '0;
      cells         <= '0;
      frame_done    <= 1'b0;
      cells_changed <= 1'b0;
      flipped       <= 1'b0;
      for (int c = 0; c < N*N; c++) deb_cnt[c] <= '0;
    end else begin
      state         <= state_d;
      x             <= x_d;
      settle_cnt    <= settle_d;
      cells         <= cells_d;
      frame_done    <= frame_done_d;
      // A flip on the final sample of the frame still counts for this frame
      cells_changed <= frame_done_d & (flipped | flip_now);
      flipped       <= frame_done_d ? 1'b0 : (flipped | flip_now);
      deb_cnt       <= deb_d;
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: a frame-position model of the scan and per-cell
// debounce, driven by directed matrix scenarios followed by random traffic.
module tb_key_matrix_scanner;

  localparam int N  = 3;
  localparam int S  = 2;
  localparam int D  = 3;
  localparam int NC = N * N;
  localparam int CP = S + 1;
  localparam int FL = N * CP;

  logic              clk = 1'b0;
  logic              rst_n, ena;
  logic [N-1:0]      row_sense;
  logic [N-1:0]      cols;
  logic [$clog2(N):0] x;
  logic [NC-1:0]     cells;
  logic              frame_done, cells_changed;

  always #5 clk = ~clk;

  key_matrix_scanner #(.N(N), .SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .row_sense(row_sense),
    .cols(cols), .x(x), .cells(cells),
    .frame_done(frame_done), .cells_changed(cells_changed)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int fd_seen      = 0;
  int cc_seen      = 0;

  // Model: position within the frame plus per-cell disagreement counts
  bit            m_active  = 1'b0;
  int            m_pos     = 0;
  logic [NC-1:0] m_cells   = '0;
  int            m_deb [NC];
  bit            m_flipped = 1'b0;
  bit            m_fd      = 1'b0;
  bit            m_cc      = 1'b0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic e, input logic rn, input logic [N-1:0] row);
    int col;
    m_fd = 1'b0;
    m_cc = 1'b0;
    if (!rn) begin
      m_active  = 1'b0;
      m_pos     = 0;
      m_cells   = '0;
      m_flipped = 1'b0;
      for (int i = 0; i < NC; i++) m_deb[i] = 0;
    end else if (!m_active) begin
      if (e) begin
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else begin
      col = m_pos / CP;
      if (m_pos % CP == S) begin
        for (int r = 0; r < N; r++) begin
          int c;
          c = col * N + r;
          if ((!row[r]) == m_cells[c]) m_deb[c] = 0;
          else begin
            m_deb[c]++;
            if (m_deb[c] == D) begin
              m_cells[c] = ~m_cells[c];
              m_deb[c]   = 0;
              m_flipped  = 1'b1;
            end
          end
        end
        if (col == N - 1) begin
          m_fd      = 1'b1;
          m_cc      = m_flipped;
          m_flipped = 1'b0;
        end
      end
      if (m_pos == FL - 1) begin
        m_pos    = 0;
        m_active = e;
      end else m_pos++;
    end
  endtask

  task automatic checkOutput();
    cmp("cols", {29'd0, cols}, m_active ? (1 << (m_pos / CP)) : 0);
    cmp("x", {29'd0, x}, m_active ? (m_pos / CP) : 0);
    cmp("cells", {23'd0, cells}, {23'd0, m_cells});
    cmp("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    cmp("cells_changed", {31'd0, cells_changed}, {31'd0, m_cc});
    if (frame_done === 1'b1) fd_seen++;
    if (cells_changed === 1'b1) cc_seen++;
  endtask

  // mask marks pressed keys; with glitch set, rows are random outside sample cycles
  task automatic applyStimulus(input logic e, input logic rn, input logic [NC-1:0] mask, input bit glitch);
    logic [N-1:0] row;
    int col;
    row = N'($urandom);
    if (!rn) row = '0;
    else if (m_active) begin
      col = m_pos / CP;
      if (!glitch || m_pos % CP == S)
        for (int r = 0; r < N; r++) row[r] = ~mask[col * N + r];
    end
    ena       = e;
    rst_n     = rn;
    row_sense = row;
    @(posedge clk);
    modelStep(e, rn, row);
    #1;
    checkOutput();
  endtask

  task automatic runFrames(input int nframes, input logic [NC-1:0] mask, input bit glitch);
    for (int f = 0; f < nframes; f++) begin
      int cyc;
      cyc = 0;
      do begin
        applyStimulus(1'b1, 1'b1, mask, glitch);
        cyc++;
      end while (!m_fd && cyc < 2 * FL);
      cmp("frame_end", {31'd0, frame_done}, 32'd1);
    end
  endtask

  initial begin
    int cyc;
    logic [NC-1:0] mask;
    for (int i = 0; i < NC; i++) m_deb[i] = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    row_sense = '0;

    $display("[TB] reset with ena high");
    repeat (2) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    cmp("reset_cells", {23'd0, cells}, 32'd0);
    cmp("reset_cols", {29'd0, cols}, 32'd0);
    applyStimulus(1'b1, 1'b1, '0, 1'b0);
    cmp("release_cols", {29'd0, cols}, 32'd1);

    $display("[TB] idle scan");
    fd_seen = 0; cc_seen = 0;
    runFrames(2, '0, 1'b1);
    cmp("idle_fd_count", fd_seen, 2);
    cmp("idle_cc_count", cc_seen, 0);
    cmp("idle_cells", {23'd0, cells}, 32'd0);

    $display("[TB] press cell 7");
    cc_seen = 0;
    runFrames(2, 9'h080, 1'b0);
    cmp("press_not_yet", {23'd0, cells}, 32'd0);
    runFrames(1, 9'h080, 1'b0);
    cmp("press_cells", {23'd0, cells}, 32'h080);
    cmp("press_changed", {31'd0, cells_changed}, 32'd1);
    cmp("press_cc_count", cc_seen, 1);

    $display("[TB] release cell 7");
    cc_seen = 0;
    runFrames(2, '0, 1'b1);
    cmp("release_not_yet", {23'd0, cells}, 32'h080);
    runFrames(1, '0, 1'b1);
    cmp("release_cells", {23'd0, cells}, 32'd0);
    cmp("release_cc_count", cc_seen, 1);

    $display("[TB] bounce rejection");
    cc_seen = 0;
    runFrames(2, 9'h080, 1'b1);
    runFrames(1, '0, 1'b1);
    runFrames(2, 9'h080, 1'b1);
    cmp("bounce_cells", {23'd0, cells}, 32'd0);
    cmp("bounce_cc_count", cc_seen, 0);
    runFrames(1, '0, 1'b1);

    $display("[TB] ena drop mid-frame");
    cyc = 0;
    do begin
      applyStimulus(1'b1, 1'b1, '0, 1'b1);
      cyc++;
    end while (!(m_active && m_pos / CP == 1) && cyc < 2 * FL);
    cmp("drop_at_col1", {29'd0, cols}, 32'd2);
    fd_seen = 0; cyc = 0;
    do begin
      applyStimulus(1'b0, 1'b1, '0, 1'b1);
      cyc++;
    end while (m_active && cyc < 2 * FL);
    cmp("drop_fd_count", fd_seen, 1);
    applyStimulus(1'b0, 1'b1, '0, 1'b1);
    cmp("drop_idle_cols", {29'd0, cols}, 32'd0);
    cmp("drop_idle_x", {29'd0, x}, 32'd0);

    $display("[TB] reset mid-frame with a pressed cell");
    runFrames(3, 9'h080, 1'b0);
    cmp("pre_reset_cells", {23'd0, cells}, 32'h080);
    repeat (4) applyStimulus(1'b1, 1'b1, 9'h080, 1'b0);
    applyStimulus(1'b1, 1'b0, 9'h080, 1'b0);
    cmp("midreset_cells", {23'd0, cells}, 32'd0);
    cmp("midreset_cols", {29'd0, cols}, 32'd0);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    cmp("midreset_idle", {29'd0, cols}, 32'd0);

    $display("[TB] random traffic");
    mask = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 30 == 0) mask = NC'($urandom) & NC'($urandom);
      applyStimulus(($urandom % 10) != 0, ($urandom % 80) != 0, mask, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

Scans an N×N active-low push-button/switch matrix one column at a time and publishes a debounced N×N cell vector. It uses the same column-indexed, one-hot-column, active-low-row matrix convention as the LED array driver, but in the read direction. The game-of-life top level can use it to seed or edit the board from a physical key grid. Output `cells` uses the same packing as the LED driver's `cells` input, so it can feed the board state directly.

## Interface
- `N`, default 3: matrix size; legal range 1..8, checked with `$error` at elaboration.
- `SETTLE_CYCLES`, default 4: cycles a column is driven before its rows are sampled; must be ≥ 1.
- `DEBOUNCE_SCANS`, default 3: consecutive disagreeing samples needed to flip a cell; must be ≥ 1.

Ports:
- `clk`  in  1  sole clock; every register is updated on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `ena`  in  1  scan enable; sampled only in IDLE and at the end of each frame.
- `row_sense`  in  N  raw row inputs; 0 means the key at (current column, row r) is pressed. Already synchronised externally.
- `cols`  out  N  one-hot column drive, active-high; all zeros in IDLE.
- `x`  out  $clog2(N)+1  index of the column currently being driven; 0 in IDLE.
- `cells`  out  N*N  debounced key state; `cells[x*N + r]` = 1 means pressed.
- `frame_done`  out  1  one-cycle pulse after the last column of a frame is sampled.
- `cells_changed`  out  1  one-cycle pulse, coincident with `frame_done`, when any `cells` bit flipped during that frame.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - `cols` = 0 and `x` = 0.
  - If `ena`=1, next state is SETTLE with settle counter = 0 and x = 0.
- SETTLE:
  - `cols` = 1<<x.
  - The settle counter increments every cycle.
  - When the counter reaches SETTLE_CYCLES-1, next state is SAMPLE.
- SAMPLE:
  - `cols` is still 1<<x.
  - On this cycle's edge, `raw[r] = ~row_sense[r]` is applied to the debounce for cells x*N+r, for every r.
  - If x < N-1: x increments, the settle counter clears, and next state is SETTLE.
  - If x = N-1: x wraps to 0 and `frame_done` is asserted for the next cycle. Next state is SETTLE if `ena`=1, otherwise IDLE.
- Debounce, one counter per cell, width $clog2(DEBOUNCE_SCANS+1):
  - If the sample equals the current `cells` bit, the counter clears.
  - Otherwise the counter increments.
  - When the incremented value equals DEBOUNCE_SCANS, the `cells` bit inverts and the counter clears.
  - A cell is updated only when its own column is sampled.
- A per-frame sticky "flipped" flag ORs in every cell flip. It drives `cells_changed` together with `frame_done` and clears when `frame_done` is issued.
- `ena` deasserted mid-frame: the frame completes, `frame_done` fires, and the FSM then goes to IDLE. Partial frames never occur.
- `cols`, `x`, `cells`, `frame_done` and `cells_changed` come directly from registers, or are decoded only from state and x. No output path depends combinationally on `row_sense`.

## Timing
- Reset (`rst_n`=0 at an edge), from the next cycle:
  - State = IDLE; `cols`, `x`, `cells`, `frame_done`, `cells_changed` = 0.
  - All debounce counters, the settle counter and the flipped flag = 0.
- Reset mid-frame aborts immediately, and all of the above apply.
- Column period = SETTLE_CYCLES + 1 cycles. Frame = N·(SETTLE_CYCLES + 1) cycles.
- With `ena` first seen high in IDLE at cycle 0:
  - Column 0 is driven over cycles 1..SETTLE_CYCLES+1.
  - `frame_done` is high in cycle N·(SETTLE_CYCLES+1)+1.
- Continuous scanning has no gap cycles: the first SETTLE of the next frame starts in the same cycle `frame_done` is high.
- A `cells` bit changes in the cycle after the SAMPLE of its column's DEBOUNCE_SCANS-th consecutive disagreeing sample.
- Press-to-report latency is between (DEBOUNCE_SCANS-1) and DEBOUNCE_SCANS frames plus one column period.
- `row_sense` is only observed in SAMPLE cycles; glitches during SETTLE have no effect.

## Test plan
All scenarios use N=3, SETTLE_CYCLES=2, DEBOUNCE_SCANS=3, giving a 3-cycle column and a 9-cycle frame.
1. Reset: hold `rst_n`=0 for 2 cycles with `ena`=1 and `row_sense`=3'b000 -> all outputs 0 throughout; after release, `cols`=001 from the second cycle.
2. Idle scan: `ena`=1, `row_sense`=3'b111 -> `cols` runs 001×3, 010×3, 100×3 and repeats with no gaps; `x` runs 0,1,2; `frame_done` pulses every 9 cycles; `cells`=0 and `cells_changed`=0 always.
3. Press: drive `row_sense[1]`=0 only while `cols`=100 -> `cells[7]` sets after the 3rd frame's column-2 SAMPLE. `cells_changed`=1 with the 3rd `frame_done` only; all other cells remain 0.
4. Bounce rejection: press cell 7 for 2 frames, release for 1, press for 2 -> `cells[7]` stays 0 and `cells_changed` never fires.
5. Release: after scenario 3, hold `row_sense`=111 -> `cells[7]` clears after the 3rd release frame, and `cells_changed` pulses once.
6. Enable/reset mid-frame: drop `ena` while `cols`=010 -> column 2 still scans, `frame_done` fires, then `cols`=0 and `x`=0. Separately, assert `rst_n`=0 while `cells[7]`=1 mid-frame -> `cells`=0 and state is IDLE the next cycle.
